// File: rtl/mmv_ram_slave.sv
// MemoryMapped slave backed by a 2^AWIDTH-word RAM, cleared to INITVAL after reset,
// returning read data after a fixed RDLATENCY-cycle pipeline.
module mmv_ram_slave #(
    parameter int                DWIDTH    = 8,
    parameter int                AWIDTH    = 4,
    parameter int                RDLATENCY = 2,
    parameter logic [DWIDTH-1:0] INITVAL   = '0
) (
    input  logic              reset,
    input  logic              clk,
    input  logic [AWIDTH-1:0] s_addr,
    input  logic              s_wreq,
    input  logic [DWIDTH-1:0] s_wdat,
    input  logic              s_rreq,
    output logic [DWIDTH-1:0] s_rdat,
    output logic              s_rval,
    output logic              s_busy,
    input  logic              stall,
    output logic              init_done
);

    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t              r_state;
    logic [AWIDTH-1:0]   r_cnt;
    logic                r_init_done;
    logic [DWIDTH-1:0]   r_mem [DEPTH];
    logic [RDLATENCY-1:0] r_vld;
    logic [DWIDTH-1:0]   r_dat [RDLATENCY];

    logic w_busy;
    logic w_rd_acc;
    logic w_wr_acc;

    assign w_busy   = (r_state != ST_READY) || stall;
    assign w_rd_acc = s_rreq && !w_busy;
    assign w_wr_acc = s_wreq && !w_busy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; this is also what gives read-before-write on a shared edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (&r_cnt) begin
                r_state     <= ST_READY;
                r_init_done <= 1'b1;
            end
        end
    end

    // NOTE: the RAM array has no reset; the post-reset clear sweep initialises it,
    // which keeps it mappable onto plain memory cells.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= INITVAL;
        end else if (w_wr_acc) begin
            r_mem[s_addr] <= s_wdat;
        end
    end

    // Data stages only advance behind a valid bit, so s_rdat holds between responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            for (int i = 0; i < RDLATENCY; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_dat[0] <= r_mem[s_addr];
            end
            for (int i = 1; i < RDLATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign s_rdat    = r_dat[RDLATENCY-1];
    assign s_rval    = r_vld[RDLATENCY-1];
    assign s_busy    = w_busy;
    assign init_done = r_init_done;

endmodule
